alu_decode_stage: RTL and testbench

- Registered decode stage that produces the 4-bit ALU control word, the operand-B select and the extended immediate from a fetched RV32I instruction.
- Sits between fetch and the execute-stage ALU and drives the ALU's alu_ctrl input.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so no combinational path exists from out_ready to in_ready.
- A synchronous flush discards in-flight decodes on redirect.

---
 rtl/alu_decode_stage.sv | 177 +++++++++++++++++
 tb/tb_alu_decode_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage: in_instr -> alu_ctrl/alu_src/imm_ext. Latency 1 cycle, 1/cycle throughput.
// Backpressure: 2-entry skid (M + S), in_ready is registered (!S valid) so out_ready never reaches in_ready.
module alu_decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_ctrl,
  output logic             alu_src,
  output logic [WIDTH-1:0] imm_ext,
  output logic             br_take_on_zero,
  output logic             is_branch,
  output logic             illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]       alu_ctrl;
    logic             alu_src;
    logic [WIDTH-1:0] imm;
    logic             take_zero;
    logic             is_branch;
    logic             illegal;
  } dec_t;

  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  logic [6:0]       op;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b;
  logic             unused_rs1;
  dec_t             dec_in;
  logic             legal;

  assign op         = in_instr[6:0];
  assign f3         = in_instr[14:12];
  assign f7         = in_instr[31:25];
  assign unused_rs1 = ^in_instr[19:15];
  assign imm_i      = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s      = {{(WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b      = {{(WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};

  always_comb begin
    dec_in = '0;
    legal  = 1'b1;
    case (op)
      OP_R: begin
        dec_in.alu_ctrl = f3_op(f3, f7[5]);
        if (!(f7 == 7'b0000000 ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          legal = 1'b0;
      end
      OP_I: begin
        // only the right shift uses bit 30 as a variant; addi never becomes sub
        dec_in.alu_ctrl = f3_op(f3, (f3 == 3'b101) && f7[5]);
        dec_in.alu_src  = 1'b1;
        dec_in.imm      = imm_i;
        if (f3 == 3'b001 && f7 != 7'b0000000)
          legal = 1'b0;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
          legal = 1'b0;
      end
      OP_LOAD: begin
        dec_in.alu_src = 1'b1;
        dec_in.imm     = imm_i;
      end
      OP_STORE: begin
        dec_in.alu_src = 1'b1;
        dec_in.imm     = imm_s;
      end
      OP_BRANCH: begin
        dec_in.is_branch = 1'b1;
        dec_in.imm       = imm_b;
        case (f3)
          3'b000:  begin dec_in.alu_ctrl = ALU_SUB;  dec_in.take_zero = 1'b1; end
          3'b001:  begin dec_in.alu_ctrl = ALU_SUB;  dec_in.take_zero = 1'b0; end
          3'b100:  begin dec_in.alu_ctrl = ALU_SLT;  dec_in.take_zero = 1'b0; end
          3'b101:  begin dec_in.alu_ctrl = ALU_SLT;  dec_in.take_zero = 1'b1; end
          3'b110:  begin dec_in.alu_ctrl = ALU_SLTU; dec_in.take_zero = 1'b0; end
          3'b111:  begin dec_in.alu_ctrl = ALU_SLTU; dec_in.take_zero = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_in         = '0;
      dec_in.illegal = 1'b1;
    end
  end

  logic m_vld, s_vld;
  dec_t m_dat, s_dat;
  logic take_in, take_out;

  assign in_ready = !s_vld;
  assign take_in  = in_valid && in_ready;
  assign take_out = m_vld && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= '0;
      s_dat <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= '0;
      s_dat <= '0;
    end else if (take_out) begin
      // S full implies in_ready=0, so no input can arrive in the same cycle
      if (s_vld) begin
        m_dat <= s_dat;
        s_vld <= 1'b0;
      end else if (take_in) begin
        m_dat <= dec_in;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (take_in) begin
      if (!m_vld) begin
        m_dat <= dec_in;
        m_vld <= 1'b1;
      end else begin
        s_dat <= dec_in;
        s_vld <= 1'b1;
      end
    end
  end

  assign out_valid       = m_vld;
  assign alu_ctrl        = m_dat.alu_ctrl;
  assign alu_src         = m_dat.alu_src;
  assign imm_ext         = m_dat.imm;
  assign br_take_on_zero = m_dat.take_zero;
  assign is_branch       = m_dat.is_branch;
  assign illegal         = m_dat.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: expected decodes queued on accept, compared on output handshake.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  alu_ctrl;
  logic        alu_src, br_take_on_zero, is_branch, illegal;
  logic [31:0] imm_ext;

  alu_decode_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .imm_ext(imm_ext),
    .br_take_on_zero(br_take_on_zero), .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [39:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [39:0] sb[$];
  logic [39:0] cur_exp;
  vec_t        tbl[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] got_vec();
    return {alu_ctrl, alu_src, imm_ext, br_take_on_zero, is_branch, illegal};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input logic [3:0] c, input logic s,
                              input logic [31:0] imm, input logic tz, input logic br,
                              input logic il);
    vec_t v;
    v.ins = ins;
    v.exp = {c, s, imm, tz, br, il};
    return v;
  endfunction

  // Output side is popped before the input side is pushed; flush/reset discard queued entries.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_out", 64'(got_vec()), 64'hDEAD);
        else begin
          chk("sb_data", 64'(got_vec()), 64'(sb.pop_front()));
          n_out++;
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic wait_accept();
    bit acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send(input vec_t v, input bit chk_rdy);
    in_valid = 1'b1;
    in_instr = v.ins;
    cur_exp  = v.exp;
    if (chk_rdy) chk("tput_in_ready", 64'(in_ready), 1);
    wait_accept();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    logic [40:0] snap;

    // add, sub, addi, srai, bge, illegal opcode
    tbl.push_back(mk(32'h00B50533, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h40B50533, 4'h1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'hFFF00293, 4'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h4032D293, 4'h9, 1'b1, 32'h00000403, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020D463, 4'h5, 1'b0, 32'h8,        1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h0000007F, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1));
    // sw, lw, bne -4, sltu
    tbl.push_back(mk(32'h00512423, 4'h0, 1'b1, 32'h8,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'hFFC12083, 4'h0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'hFE209EE3, 4'h1, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(32'h0020B1B3, 4'h6, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
    // illegal: R f7=0100000 with and, branch f3=010, slli f7=0100000, R f7=0000001
    tbl.push_back(mk(32'h4020F1B3, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(32'h0020A463, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(32'h40209093, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(32'h022081B3, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1));
    // slli, srli, xori, or, and, sra, srl, slt
    tbl.push_back(mk(32'h00209093, 4'h7, 1'b1, 32'h2,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020D093, 4'h8, 1'b1, 32'h2,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'hFFF0C093, 4'h4, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020E1B3, 4'h3, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020F1B3, 4'h2, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h4020D1B3, 4'h9, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020D1B3, 4'h8, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020A1B3, 4'h5, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
    // bltu, bgeu, beq, blt
    tbl.push_back(mk(32'h0020E463, 4'h6, 1'b0, 32'h8,        1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(32'h0020F463, 4'h6, 1'b0, 32'h8,        1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h00208463, 4'h1, 1'b0, 32'h8,        1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(32'h0020C463, 4'h5, 1'b0, 32'h8,        1'b0, 1'b1, 1'b0));

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready",  64'(in_ready), 1);
    chk("rst_payload",   64'(got_vec()), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single-cycle latency
    out_ready = 1'b1;
    chk("lat_pre_valid", 64'(out_valid), 0);
    send(tbl[0], 1'b0);
    chk("lat_out_valid", 64'(out_valid), 1);
    chk("lat_alu_ctrl",  64'(alu_ctrl), 0);
    @(posedge clk); #1;

    // full table back-to-back at one per cycle
    n0 = n_out;
    for (int i = 0; i < tbl.size(); i++) send(tbl[i], 1'b1);
    @(negedge clk); #1;
    chk("tput_count", 64'(n_out - n0), 64'(tbl.size()));
    @(posedge clk); #1;
    chk("tput_idle_valid", 64'(out_valid), 0);

    // backpressure: two fill M and S, third waits
    out_ready = 1'b0;
    n0 = n_out;
    send(tbl[2], 1'b0);
    send(tbl[3], 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 0);
    snap = {out_valid, got_vec()};
    in_valid = 1'b1; in_instr = tbl[4].ins; cur_exp = tbl[4].exp;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", 64'({out_valid, got_vec()}), 64'(snap));
    end
    out_ready = 1'b1;
    wait_accept();
    drain();
    chk("bp_count", 64'(n_out - n0), 3);

    // flush with M and S full and in_valid asserted
    out_ready = 1'b0;
    send(tbl[5], 1'b0);
    send(tbl[6], 1'b0);
    in_valid = 1'b1; in_instr = tbl[7].ins; cur_exp = tbl[7].exp; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", 64'(out_valid), 0);
    chk("flush_full_ready", 64'(in_ready), 1);

    // flush with M full and a real simultaneous input transfer
    send(tbl[8], 1'b0);
    in_valid = 1'b1; in_instr = tbl[9].ins; cur_exp = tbl[9].exp; flush = 1'b1;
    chk("flush_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_valid", 64'(out_valid), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("flush_no_ghost", 64'(out_valid), 0);
    end
    n0 = n_out;
    send(tbl[15], 1'b0);
    drain();
    chk("post_flush_count", 64'(n_out - n0), 1);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(tbl[16], 1'b0);
    send(tbl[17], 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_in_ready",  64'(in_ready), 1);
    chk("arst_payload",   64'(got_vec()), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n0 = n_out;
    out_ready = 1'b1;
    send(tbl[1], 1'b0);
    drain();
    chk("post_rst_count", 64'(n_out - n0), 1);
    chk("sb_final_empty", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
